// File: rtl/layer0_patch_engine.sv
// layer0_patch_engine: per-pixel layer-0 conv sequencer (27 INT8 MACs + bias + LeakyReLU + requant per channel)
// Ports: start/scale kick one pixel; busy/done report progress;
//   w_*/a_* drive 1-cycle-latency weight/activation memories; b_* reads the channel bias;
//   out_valid/out_ready/out_ch/out_data stream one INT8 result per channel.
module layer0_patch_engine #(
  parameter int NUM_CH  = 4,
  parameter int K       = 27,
  parameter int SCALE_Q = 16,
  parameter int AW_W    = $clog2(NUM_CH*K),
  parameter int AW_A    = $clog2(K),
  parameter int AW_B    = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     scale,
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [AW_W-1:0] w_addr,
  input  logic [7:0]      w_rdata,
  output logic            a_rd_en,
  output logic [AW_A-1:0] a_addr,
  input  logic [7:0]      a_rdata,
  output logic [AW_B-1:0] b_addr,
  input  logic [31:0]     b_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW_B-1:0] out_ch,
  output logic [7:0]      out_data
);
  localparam int KW = $clog2(K+1);
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_POST, S_REQ, S_OUT, S_FIN} state_t;
  state_t                  r_state;
  logic [AW_B-1:0]         r_ch;
  logic [KW-1:0]           r_k;
  logic signed [31:0]      r_acc, r_y;
  logic [15:0]             r_scale;
  logic                    r_busy, r_done, r_valid;
  logic [AW_B-1:0]         r_out_ch;
  logic [7:0]              r_out_data;
  logic                    w_rd;
  logic signed [15:0]      w_prod;
  logic signed [31:0]      w_x, w_leaky;
  logic signed [47:0]      w_y48, w_s48, w_p, w_r;
  logic [7:0]              w_sat;
  assign w_rd      = (r_state == S_MAC) && (r_k < KW'(K));
  assign w_rd_en   = w_rd;
  assign a_rd_en   = w_rd;
  assign w_addr    = w_rd ? AW_W'(int'(r_ch) * K + int'(r_k)) : '0;
  assign a_addr    = w_rd ? AW_A'(r_k) : '0;
  assign b_addr    = r_ch;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;
  assign w_prod    = $signed(w_rdata) * $signed(a_rdata);
  assign w_x       = r_acc + $signed(b_rdata);
  // LeakyReLU with slope 1/8 as an arithmetic shift (rounds toward -inf)
  assign w_leaky   = w_x[31] ? (w_x >>> 3) : w_x;
  assign w_y48     = {{16{r_y[31]}}, r_y};
  assign w_s48     = {32'd0, r_scale};
  assign w_p       = w_y48 * w_s48;
  assign w_r       = (w_p + (48'sd1 <<< (SCALE_Q-1))) >>> SCALE_Q;
  assign w_sat     = (w_r > 48'sd127) ? 8'h7f : (w_r < -48'sd128) ? 8'h80 : w_r[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_y        <= '0;
      r_scale    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_out_ch   <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_scale <= scale;
            r_ch    <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          // read data for address k-1 arrives during cycle k
          if (r_k != '0) r_acc <= r_acc + {{16{w_prod[15]}}, w_prod};
          r_k <= r_k + KW'(1);
          if (r_k == KW'(K)) r_state <= S_POST;
        end
        S_POST: begin
          r_y     <= w_leaky;
          r_state <= S_REQ;
        end
        S_REQ: begin
          r_out_data <= w_sat;
          r_out_ch   <= r_ch;
          r_valid    <= 1'b1;
          r_state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (r_ch == AW_B'(NUM_CH-1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_ch    <= r_ch + AW_B'(1);
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer0_patch_engine.sv
// tb_layer0_patch_engine: directed self-checking bench for layer0_patch_engine
module tb_layer0_patch_engine;
  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [15:0] scale;
  logic        busy, done, w_rd_en, a_rd_en, out_valid;
  logic [6:0]  w_addr;
  logic [4:0]  a_addr;
  logic [1:0]  b_addr, out_ch;
  logic [7:0]  w_rdata, a_rdata, out_data;
  logic [31:0] b_rdata;
  logic [7:0]  wmem [108];
  logic [7:0]  amem [27];
  logic [31:0] bmem [4];
  logic [7:0]  res_d [4];
  logic [1:0]  res_c [4];
  int          res_t [4];
  int          res_n, done_cnt, n_chk, n_fail;

  always #5 clk = ~clk;

  layer0_patch_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data)
  );

  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= wmem[w_addr];
    if (a_rd_en) a_rdata <= amem[a_addr];
  end
  assign b_rdata = bmem[b_addr];

  task automatic fill(input int w0, input int w1, input int w2, input int w3, input int a,
                      input int b0, input int b1, input int b2, input int b3);
    for (int k = 0; k < 27; k++) begin
      wmem[k] = 8'(w0); wmem[27+k] = 8'(w1); wmem[54+k] = 8'(w2); wmem[81+k] = 8'(w3);
      amem[k] = 8'(a);
    end
    bmem[0] = 32'(b0); bmem[1] = 32'(b1); bmem[2] = 32'(b2); bmem[3] = 32'(b3);
  endtask

  // Runs one pixel with out_ready=1; records results and the cycle (after start edge) each was seen.
  // poke: cycle at which start is re-pulsed while busy; start is also pulsed during the done cycle.
  task automatic run_collect(input logic [15:0] sc, input int poke);
    res_n = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1; scale = sc;
    @(posedge clk); #1; start = 1'b0; scale = 16'h0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && out_ready && res_n < 4) begin
        res_d[res_n] = out_data; res_c[res_n] = out_ch; res_t[res_n] = cyc; res_n++;
      end
      if (done) done_cnt++;
      start = (cyc == poke) || done;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    n_chk++;
    if (res_n !== 4) begin n_fail++; $display("FAIL %s_count: got %0d results, expected 4", nm, res_n); end
    for (int i = 0; i < res_n; i++) begin
      n_chk++;
      if (res_d[i] !== e[i] || res_c[i] !== 2'(i)) begin
        n_fail++;
        $display("FAIL %s_ch%0d: got ch=%0d data=%h, expected ch=%0d data=%h", nm, i, res_c[i], res_d[i], i, e[i]);
      end
    end
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done: got %0d pulses, expected 1", nm, done_cnt); end
  endtask

  task automatic test_reset;
    n_chk++;
    if ({busy, done, out_valid, w_rd_en, a_rd_en, w_addr, a_addr, b_addr, out_ch, out_data} !== 29'd0) begin
      n_fail++; $display("FAIL reset_state: busy=%b done=%b valid=%b rd=%b%b data=%h", busy, done, out_valid, w_rd_en, a_rd_en, out_data);
    end
  endtask

  task automatic test_basic;
    fill(1, 1, 1, 1, 1, 0, 0, 0, 0);
    run_collect(16'd32768, -1);
    check_results("basic", 8'h0e, 8'h0e, 8'h0e, 8'h0e);
  endtask

  task automatic test_negative;
    fill(-1, -1, -1, -1, 2, 0, 0, 0, 0);
    run_collect(16'd65535, -1);
    check_results("leaky", 8'hf9, 8'hf9, 8'hf9, 8'hf9);
  endtask

  task automatic test_saturation;
    fill(127, -128, 0, 0, 127, 0, 0, 100, 0);
    run_collect(16'd65535, -1);
    check_results("sat_full", 8'h7f, 8'h80, 8'h64, 8'h00);
    run_collect(16'd655, -1);
    check_results("sat_small", 8'h7f, 8'h80, 8'h01, 8'h00);
  endtask

  task automatic test_timing;
    fill(1, 1, 1, 1, 1, 0, 0, 0, 0);
    run_collect(16'd32768, 10);
    check_results("timing", 8'h0e, 8'h0e, 8'h0e, 8'h0e);
    n_chk++;
    if (res_t[0] !== 30) begin n_fail++; $display("FAIL first_latency: got %0d cycles, expected 30", res_t[0]); end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (res_t[i] - res_t[i-1] !== 31) begin
        n_fail++; $display("FAIL ch_interval%0d: got %0d cycles, expected 31", i, res_t[i] - res_t[i-1]);
      end
    end
    n_chk++;
    if (busy !== 1'b0 || w_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL start_in_fin: got busy=%b rd=%b, expected 0 0", busy, w_rd_en);
    end
  endtask

  task automatic test_backpressure;
    int t;
    bit bad;
    fill(1, 1, 1, 1, 1, 0, 0, 0, 0);
    out_ready = 1'b0;
    @(negedge clk); start = 1'b1; scale = 16'd32768;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    n_chk++;
    if (out_ch !== 2'd1 || out_data !== 8'h0e) begin
      n_fail++; $display("FAIL bp_first: got ch=%0d data=%h, expected ch=1 data=0e", out_ch, out_data);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h0e || w_rd_en !== 1'b0 || a_rd_en !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b ch=%0d data=%h rd=%b%b, expected 1 1 0e 00", out_valid, out_ch, out_data, w_rd_en, a_rd_en);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || w_rd_en !== 1'b1 || a_rd_en !== 1'b1 || w_addr !== 7'd54 || a_addr !== 5'd0 || b_addr !== 2'd2) begin
      n_fail++; $display("FAIL bp_resume: got valid=%b rd=%b%b w_addr=%0d a_addr=%0d b_addr=%0d, expected 0 11 54 0 2",
                         out_valid, w_rd_en, a_rd_en, w_addr, a_addr, b_addr);
    end
    t = 0;
    while (!done && t < 200) begin @(posedge clk); #1; t++; end
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got done=%b, expected 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    int t;
    fill(2, -3, 5, 0, 1, 10, 0, -200, -1000);
    @(negedge clk); start = 1'b1; scale = 16'd40000;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (!(b_addr == 2'd1 && w_rd_en) && t < 200) begin @(posedge clk); #1; t++; end
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++;
    if (t >= 200 || {busy, done, out_valid, w_rd_en, a_rd_en, w_addr, a_addr, b_addr, out_ch, out_data} !== 29'd0) begin
      n_fail++; $display("FAIL midrun_reset: waited=%0d busy=%b valid=%b rd=%b b_addr=%0d, expected all 0", t, busy, out_valid, w_rd_en, b_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_collect(16'd40000, -1);
    check_results("golden", 8'h27, 8'hf9, 8'hfb, 8'hb4);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; scale = 16'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_basic;
    test_negative;
    test_saturation;
    test_timing;
    test_backpressure;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/layer0_patch_engine.md
Name: layer0_patch_engine

Overview:
Hardware sequencer for one layer-0 output pixel: reads 27 weights per channel, the shared 27-entry activation patch and one bias per channel from synchronous memories. Per channel it runs 27 INT8 MACs, adds bias, applies LeakyReLU and requantizes to INT8. Results leave through a valid/ready stream. This is the memory-reader/controller side that replaces the software-driven MAC/LeakyReLU/requantize sequence; outputs match the Python golden used for the layer-0 patch check.

Parameters:
NUM_CH, 4, output channels processed per start
K, 27, MACs per channel (3x3x3 kernel)
SCALE_Q, 16, fractional bits of requantize scale
AW_W, $clog2(NUM_CH*K), weight address width
AW_A, $clog2(K), activation address width
AW_B, $clog2(NUM_CH), bias address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one pixel; sampled only in IDLE
scale  in  16  unsigned requant scale, sampled at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last channel handshake
w_rd_en  out  1  weight memory read enable
w_addr  out  AW_W  weight address = ch*K + k
w_rdata  in  8  signed weight, valid 1 cycle after w_rd_en
a_rd_en  out  1  activation read enable (same timing as w_rd_en)
a_addr  out  AW_A  activation address = k
a_rdata  in  8  signed activation, 1-cycle latency
b_addr  out  AW_B  bias address = ch, held for whole channel
b_rdata  in  32  signed bias, stable while b_addr held
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_ch  out  AW_B  channel index of out_data
out_data  out  8  signed INT8 result

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, out_valid, w_rd_en, a_rd_en = 0; addresses, out_ch, out_data, accumulator = 0; scale register = 0.
- States: IDLE -> MAC -> POST -> REQ -> OUT -> (MAC for next ch | FIN) -> IDLE.
- IDLE: start=1 at edge: latch scale, ch=0, k=0, acc=0, busy=1, go MAC. start ignored in every other state.
- MAC: K+1 cycles, counter k=0..K. For k<K: rd_en=1, addresses issued combinationally from counters. For k>=1: acc += w_rdata*a_rdata (16-bit signed product, sign-extended, 32-bit wrap). After k=K go POST.
- POST (1 cycle): x = acc + b_rdata (32-bit wrap); y = x>=0 ? x : x>>>3; register y.
- REQ (1 cycle): p = y * {0,scale} (48-bit signed); r = (p + 2^(SCALE_Q-1)) >>> SCALE_Q; saturate to [-128,127]; register out_data, out_ch=ch, out_valid=1; go OUT.
- OUT: hold out_valid, out_data, out_ch stable until out_valid&&out_ready. On handshake: out_valid=0. If ch<NUM_CH-1: ch++, k=0, acc=0, go MAC. Else go FIN.
- FIN (1 cycle): done=1, busy=0 at this edge's output; next IDLE. start in FIN ignored.
- Latency: start edge E0; out_valid ch0 high after edge E(K+3) = 30 cycles with defaults. Per channel with out_ready=1: K+4 cycles.
- No memory reads during POST/REQ/OUT/FIN. Stall in OUT indefinitely allowed.
- Reset mid-operation: all state cleared immediately, partial results discarded; no done pulse.

Test Plan:
- All w=1, a=1, bias=0, scale=32768 -> each channel out_data=14 (acc 27); out_ch 0,1,2,3 in order; done pulses once.
- w=-1, a=2, bias=0, scale=65535 -> acc=-54, leaky -7, out_data=-7 on all channels.
- Saturation: ch0 w=127,a=127,scale=655 -> 127; ch1 w=-128,a=127,scale=65535 -> -128; bias=100 on ch2 with w=a=0,scale=65535 -> 100.
- Backpressure: out_ready low 10 cycles on ch1 -> out_valid/out_data/out_ch held, w_rd_en=a_rd_en=0 throughout; ch2 reads start the cycle after handshake.
- Timing: out_ready tied 1 -> out_valid ch0 exactly 30 cycles after start edge, subsequent channels every 31 cycles; start pulsed while busy has no effect.
- Reset: rst_n low during MAC of ch1 -> all outputs 0 same cycle; release and restart -> four correct results matching golden hex.
